miner_job_dispatcher: RTL and testbench
=======================================

// Module: miner_job_dispatcher
// PURPOSE
// Host-side initiator for the topLevelMiner target/message interface. Accepts one mining job
// (target, header template, nonce range), loads the target, then sweeps the nonce: insert, pulse
// newMsg, wait a fixed hash latency, sample validBTC. Reports first winning nonce+hash or range
// exhaustion. Sits between the host/job register block and topLevelMiner.
// PARAMETERS
// MSG_W         1944  width of header/inputMsg in bits
// NONCE_LSB     0     bit position of nonce LSB inside inputMsg (NONCE_LSB+32 <= MSG_W)
// TGT_SETTLE    2     idle cycles after newTarget pulse before first newMsg (>=1)
// HASH_LATENCY  500   cycles from newMsg pulse to validBTC/SHAoutput sample (>=1)
// PORTS
// clk           in   1      system clock, rising edge
// n_rst         in   1      asynchronous active-low reset
// job_valid     in   1      job offered; accepted when job_valid && job_ready
// job_ready     out  1      high only in IDLE
// job_target    in   256    difficulty target for the job
// job_header    in   MSG_W  message template; nonce field overwritten
// nonce_start   in   32     first nonce tried
// nonce_end     in   32     last nonce tried (inclusive)
// abort         in   1      cancel running job, return to IDLE
// newTarget     out  1      1-cycle pulse to miner
// inputTarget   out  256    target to miner, held stable while busy
// newMsg        out  1      1-cycle pulse to miner
// inputMsg      out  MSG_W  header with current nonce, stable from newMsg to sample
// validBTC      in   1      miner: hash meets target
// SHAoutput     in   256    miner: hash of last message
// busy          out  1      high in every state except IDLE
// cur_nonce     out  32     nonce currently in flight
// found         out  1      1-cycle pulse: winning nonce
// found_nonce   out  32     winning nonce, valid from found until next acceptance
// found_hash    out  256    SHAoutput captured with found
// exhausted     out  1      1-cycle pulse: range done, no winner
// BEHAVIOUR
// - Reset: all outputs 0 except job_ready=1; FSM=IDLE; counters 0. Reset mid-job drops job, no pulse.
// - All outputs registered. Job fields latched in the acceptance cycle; later input changes ignored.
// - FSM: IDLE -accept-> LOAD_TGT (newTarget=1, inputTarget=job_target) -> TGT_WAIT (TGT_SETTLE
//   cycles) -> SEND (newMsg=1, inputMsg=header with nonce at [NONCE_LSB+:32]) -> WAIT
//   (HASH_LATENCY-1 cycles) -> CHECK (samples validBTC/SHAoutput).
// - CHECK: validBTC=1 -> found=1, capture nonce/hash, IDLE. Else nonce==nonce_end -> exhausted=1,
//   IDLE. Else nonce<=nonce+1 (mod 2^32) -> SEND. No TGT_WAIT between nonces.
// - newMsg-to-CHECK spacing is exactly HASH_LATENCY cycles; one nonce per HASH_LATENCY+1 cycles.
// - Wrap: nonce_start > nonce_end sweeps through FFFFFFFF to 0 and on to nonce_end. start==end is
//   one hash. Full range (start=end+1) tries all 2^32 nonces.
// - abort (any non-IDLE state) -> IDLE next cycle, no found/exhausted, newMsg/newTarget forced 0.
//   abort in IDLE ignored. abort with validBTC in CHECK: abort wins.
// - job_valid while busy not accepted (job_ready=0). Accept-to-IDLE return has >=1 IDLE cycle.
// - found and exhausted are mutually exclusive and never both 1.
// TESTING (bench model: miner sets validBTC when nonce==W, HASH_LATENCY=8, TGT_SETTLE=2)
// 1 reset: busy=0, job_ready=1, newMsg=newTarget=found=exhausted=0, inputMsg=0.
// 2 target 256'h1000..0, start=5, end=9, W=7 -> newTarget once; newMsg for nonces 5,6,7;
//   found=1, found_nonce=7, found_hash=model hash; exactly 9 cycles newMsg-to-newMsg.
// 3 start=FFFFFFFE, end=1, no W -> nonces FFFFFFFE,FFFFFFFF,0,1 in order; exhausted=1, found=0.
// 4 start=end=3, W=3 -> single newMsg, found_nonce=3; then W=4 -> single newMsg, exhausted.
// 5 abort 3 cycles after 2nd newMsg -> IDLE next cycle, no pulses, job_ready=1, new job accepted.
// 6 n_rst low mid-WAIT -> outputs to reset values immediately; job_valid held high while busy
//   never handshakes.

Source files
------------

// File: rtl/miner_job_dispatcher.sv
// miner_job_dispatcher: host-side initiator for the topLevelMiner target/message interface.
// Accepts one job, loads the target, then sweeps nonces one hash at a time and reports either
// the first winning nonce/hash or exhaustion of the range.
module miner_job_dispatcher #(
    parameter int unsigned MSG_W        = 1944,
    parameter int unsigned NONCE_LSB    = 0,
    parameter int unsigned TGT_SETTLE   = 2,
    parameter int unsigned HASH_LATENCY = 500
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [255:0]       job_target,
    input  logic [MSG_W-1:0]   job_header,
    input  logic [31:0]        nonce_start,
    input  logic [31:0]        nonce_end,
    input  logic               abort,
    output logic               newTarget,
    output logic [255:0]       inputTarget,
    output logic               newMsg,
    output logic [MSG_W-1:0]   inputMsg,
    input  logic               validBTC,
    input  logic [255:0]       SHAoutput,
    output logic               busy,
    output logic [31:0]        cur_nonce,
    output logic               found,
    output logic [31:0]        found_nonce,
    output logic [255:0]       found_hash,
    output logic               exhausted
);

    typedef enum logic [2:0] {StIdle, StLoadTgt, StTgtWait, StSend, StWait, StCheck} state_e;

    // Down-counter reload values: a counter loaded with N spends N+1 cycles in its state.
    localparam logic [31:0] SettleLoad = 32'(TGT_SETTLE - 1);
    localparam logic [31:0] WaitLoad   = (HASH_LATENCY >= 2) ? 32'(HASH_LATENCY - 2) : 32'd0;

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        nonce_q, nonce_d;
    logic [31:0]        end_q, end_d;
    logic [MSG_W-1:0]   hdr_q, hdr_d;
    logic               job_ready_q, job_ready_d;
    logic               busy_q, busy_d;
    logic               new_target_q, new_target_d;
    logic [255:0]       input_target_q, input_target_d;
    logic               new_msg_q, new_msg_d;
    logic [MSG_W-1:0]   input_msg_q, input_msg_d;
    logic               found_q, found_d;
    logic [31:0]        found_nonce_q, found_nonce_d;
    logic [255:0]       found_hash_q, found_hash_d;
    logic               exhausted_q, exhausted_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        nonce_d        = nonce_q;
        end_d          = end_q;
        hdr_d          = hdr_q;
        input_target_d = input_target_q;
        input_msg_d    = input_msg_q;
        found_nonce_d  = found_nonce_q;
        found_hash_d   = found_hash_q;
        new_target_d   = 1'b0;
        new_msg_d      = 1'b0;
        found_d        = 1'b0;
        exhausted_d    = 1'b0;

        if (abort && (state_q != StIdle)) begin
            // Abort beats everything, including a winning validBTC in CHECK.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (job_valid && job_ready_q) begin
                        input_target_d = job_target;
                        hdr_d          = job_header;
                        nonce_d        = nonce_start;
                        end_d          = nonce_end;
                        cnt_d          = SettleLoad;
                        new_target_d   = 1'b1;
                        state_d        = StLoadTgt;
                    end
                end
                StLoadTgt: state_d = StTgtWait;
                StTgtWait: begin
                    if (cnt_q == 32'd0) begin
                        input_msg_d                  = hdr_q;
                        input_msg_d[NONCE_LSB +: 32] = nonce_q;
                        new_msg_d                    = 1'b1;
                        state_d                      = StSend;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                StSend: begin
                    cnt_d   = WaitLoad;
                    state_d = (HASH_LATENCY >= 2) ? StWait : StCheck;
                end
                StWait: begin
                    if (cnt_q == 32'd0) begin
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                StCheck: begin
                    if (validBTC) begin
                        found_d       = 1'b1;
                        found_nonce_d = nonce_q;
                        found_hash_d  = SHAoutput;
                        state_d       = StIdle;
                    end else if (nonce_q == end_q) begin
                        exhausted_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        // Wraps naturally through FFFFFFFF to 0.
                        nonce_d                      = nonce_q + 32'd1;
                        input_msg_d                  = hdr_q;
                        input_msg_d[NONCE_LSB +: 32] = nonce_d;
                        new_msg_d                    = 1'b1;
                        state_d                      = StSend;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d      = (state_d != StIdle);
        job_ready_d = (state_d == StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            nonce_q        <= '0;
            end_q          <= '0;
            hdr_q          <= '0;
            job_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            new_target_q   <= 1'b0;
            input_target_q <= '0;
            new_msg_q      <= 1'b0;
            input_msg_q    <= '0;
            found_q        <= 1'b0;
            found_nonce_q  <= '0;
            found_hash_q   <= '0;
            exhausted_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            nonce_q        <= nonce_d;
            end_q          <= end_d;
            hdr_q          <= hdr_d;
            job_ready_q    <= job_ready_d;
            busy_q         <= busy_d;
            new_target_q   <= new_target_d;
            input_target_q <= input_target_d;
            new_msg_q      <= new_msg_d;
            input_msg_q    <= input_msg_d;
            found_q        <= found_d;
            found_nonce_q  <= found_nonce_d;
            found_hash_q   <= found_hash_d;
            exhausted_q    <= exhausted_d;
        end
    end

    assign job_ready   = job_ready_q;
    assign busy        = busy_q;
    assign newTarget   = new_target_q;
    assign inputTarget = input_target_q;
    assign newMsg      = new_msg_q;
    assign inputMsg    = input_msg_q;
    assign cur_nonce   = nonce_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign exhausted   = exhausted_q;

endmodule

// File: tb/tb_miner_job_dispatcher.sv
// Testbench for miner_job_dispatcher: behavioural miner that wins on one nonce, a scoreboard of
// expected nonces checked on every newMsg, a job vector table and hand-written abort/reset cases.
module tb_miner_job_dispatcher;

    localparam int MW = 64;
    localparam int NL = 8;
    localparam int TS = 2;
    localparam int HL = 8;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            job_valid = 1'b0;
    logic            job_ready;
    logic [255:0]    job_target = '0;
    logic [MW-1:0]   job_header = '0;
    logic [31:0]     nonce_start = '0;
    logic [31:0]     nonce_end = '0;
    logic            abort = 1'b0;
    logic            newTarget;
    logic [255:0]    inputTarget;
    logic            newMsg;
    logic [MW-1:0]   inputMsg;
    logic            validBTC = 1'b0;
    logic [255:0]    SHAoutput = '0;
    logic            busy;
    logic [31:0]     cur_nonce;
    logic            found;
    logic [31:0]     found_nonce;
    logic [255:0]    found_hash;
    logic            exhausted;

    miner_job_dispatcher #(
        .MSG_W(MW), .NONCE_LSB(NL), .TGT_SETTLE(TS), .HASH_LATENCY(HL)
    ) dut (
        .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_target(job_target), .job_header(job_header), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .abort(abort), .newTarget(newTarget), .inputTarget(inputTarget),
        .newMsg(newMsg), .inputMsg(inputMsg), .validBTC(validBTC), .SHAoutput(SHAoutput),
        .busy(busy), .cur_nonce(cur_nonce), .found(found), .found_nonce(found_nonce),
        .found_hash(found_hash), .exhausted(exhausted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int nt_cnt = 0;
    int msg_cnt = 0;
    int fnd_cnt = 0;
    int exh_cnt = 0;
    int last_msg = -1;
    logic [31:0]   exp_q[$];
    logic [255:0]  exp_target = '0;
    logic [MW-1:0] exp_hdr = '0;
    logic          win_en_m = 1'b0;
    logic [31:0]   win_m = '0;
    logic [31:0]   seen_nonce = '0;

    localparam logic [MW-1:0] NonceMask = ~({{(MW-32){1'b0}}, 32'hFFFF_FFFF} << NL);

    function automatic logic [255:0] model_hash(input logic [31:0] n);
        return {8{n ^ 32'hA5A5_0000}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (n_rst && job_valid && job_ready) acc_cnt <= acc_cnt + 1;
    end

    // Behavioural miner: latches the nonce on newMsg, answers well before CHECK samples.
    always @(negedge clk) begin
        if (newMsg) begin
            seen_nonce = inputMsg[NL +: 32];
            validBTC   = win_en_m && (seen_nonce == win_m);
            SHAoutput  = model_hash(seen_nonce);
        end
    end

    // Output monitor and nonce scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        if (newTarget) begin
            nt_cnt++;
            chk("inputTarget", inputTarget, exp_target);
            last_msg = -1;
        end
        if (newMsg) begin
            msg_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_newMsg: got nonce %0h expected none", inputMsg[NL +: 32]);
            end else begin
                e = exp_q.pop_front();
                chk("msg_nonce", 256'(inputMsg[NL +: 32]), 256'(e));
                chk("cur_nonce", 256'(cur_nonce), 256'(e));
            end
            chk("msg_header", 256'(inputMsg & NonceMask), 256'(exp_hdr & NonceMask));
            chk("target_stable", inputTarget, exp_target);
            if (last_msg >= 0) chk("msg_spacing", 256'(cyc - last_msg), 256'(HL + 1));
            last_msg = cyc;
        end
        if (found) fnd_cnt++;
        if (exhausted) exh_cnt++;
        if (found && exhausted) begin
            checks++;
            errors++;
            $display("FAIL found_and_exhausted: got both 1 expected at most one");
        end
    end

    typedef struct {
        logic [255:0] target;
        logic [31:0]  start;
        logic [31:0]  stop;
        logic         win_en;
        logic [31:0]  win;
        logic         exp_found;
        logic [31:0]  exp_nonce;
        int           exp_msgs;
    } vec_t;

    vec_t vecs[5];

    task automatic start_job(input vec_t v, input int n_push);
        logic [31:0] n;
        logic [MW-1:0] hdr;
        hdr = {$urandom, $urandom};
        win_en_m = v.win_en;
        win_m = v.win;
        exp_target = v.target;
        exp_hdr = hdr;
        n = v.start;
        for (int i = 0; i < n_push; i++) begin
            exp_q.push_back(n);
            n++;
        end
        job_valid = 1'b1;
        job_target = v.target;
        job_header = hdr;
        nonce_start = v.start;
        nonce_end = v.stop;
    endtask

    task automatic run_job(input vec_t v);
        int t;
        int nt0;
        int m0;
        @(negedge clk);
        chk("job_ready_idle", 256'(job_ready), 256'(1));
        nt0 = nt_cnt;
        m0 = msg_cnt;
        start_job(v, v.exp_msgs);
        @(negedge clk);
        // Scramble the inputs: the job must already be latched.
        job_valid = 1'b0;
        job_target = '1;
        job_header = ~job_header;
        nonce_start = 32'hDEAD_BEEF;
        nonce_end = 32'hDEAD_BEEF;
        chk("busy_after_accept", 256'(busy), 256'(1));
        chk("ready_after_accept", 256'(job_ready), 256'(0));
        t = 0;
        while (!(found || exhausted) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got no found/exhausted expected one within 400 cycles");
        end else begin
            chk("found", 256'(found), 256'(v.exp_found));
            chk("exhausted", 256'(exhausted), 256'(!v.exp_found));
            if (v.exp_found) begin
                chk("found_nonce", 256'(found_nonce), 256'(v.exp_nonce));
                chk("found_hash", found_hash, model_hash(v.exp_nonce));
            end
            chk("busy_done", 256'(busy), 256'(0));
            chk("ready_done", 256'(job_ready), 256'(1));
        end
        @(negedge clk);
        chk("found_pulse_1cyc", 256'(found), 256'(0));
        chk("exh_pulse_1cyc", 256'(exhausted), 256'(0));
        chk("newTarget_count", 256'(nt_cnt - nt0), 256'(1));
        chk("newMsg_count", 256'(msg_cnt - m0), 256'(v.exp_msgs));
        chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        exp_q.delete();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: got no finish expected finish by 300000");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int m0;
        int f0;
        int e0;
        int a0;
        vec_t v;

        vecs[0] = '{{16'h1000, 240'h0}, 32'd5, 32'd9, 1'b1, 32'd7, 1'b1, 32'd7, 3};
        vecs[1] = '{256'h55, 32'hFFFF_FFFE, 32'd1, 1'b0, 32'd0, 1'b0, 32'd0, 4};
        vecs[2] = '{256'h33, 32'd3, 32'd3, 1'b1, 32'd3, 1'b1, 32'd3, 1};
        vecs[3] = '{256'h44, 32'd3, 32'd3, 1'b1, 32'd4, 1'b0, 32'd0, 1};
        vecs[4] = '{256'h66, 32'd10, 32'd12, 1'b1, 32'd12, 1'b1, 32'd12, 3};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_job_ready", 256'(job_ready), 256'(1));
        chk("rst_newMsg", 256'(newMsg), 256'(0));
        chk("rst_newTarget", 256'(newTarget), 256'(0));
        chk("rst_found", 256'(found), 256'(0));
        chk("rst_exhausted", 256'(exhausted), 256'(0));
        chk("rst_inputMsg", 256'(inputMsg), 256'(0));
        n_rst = 1'b1;

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // Abort three cycles after the second newMsg
        v = '{256'h77, 32'd20, 32'd30, 1'b0, 32'd0, 1'b0, 32'd0, 2};
        @(negedge clk);
        m0 = msg_cnt;
        start_job(v, 2);
        @(negedge clk);
        job_valid = 1'b0;
        t = 0;
        while (msg_cnt < m0 + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach_2nd_msg", 256'(msg_cnt - m0), 256'(2));
        repeat (3) @(negedge clk);
        f0 = fnd_cnt;
        e0 = exh_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_ready", 256'(job_ready), 256'(1));
        chk("abort_newMsg", 256'(newMsg), 256'(0));
        repeat (20) @(negedge clk);
        chk("abort_no_more_msgs", 256'(msg_cnt - m0), 256'(2));
        chk("abort_no_found", 256'(fnd_cnt - f0), 256'(0));
        chk("abort_no_exh", 256'(exh_cnt - e0), 256'(0));
        exp_q.delete();
        run_job(vecs[2]);

        // Reset mid-WAIT with job_valid held high throughout
        v = '{256'h88, 32'd40, 32'd50, 1'b0, 32'd0, 1'b0, 32'd0, 2};
        @(negedge clk);
        m0 = msg_cnt;
        a0 = acc_cnt;
        start_job(v, 2);
        t = 0;
        while (msg_cnt < m0 + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reach_2nd_msg", 256'(msg_cnt - m0), 256'(2));
        chk("held_valid_one_accept", 256'(acc_cnt - a0), 256'(1));
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b0;
        job_valid = 1'b0;
        #1;
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_ready", 256'(job_ready), 256'(1));
        chk("midrst_newMsg", 256'(newMsg), 256'(0));
        chk("midrst_inputMsg", 256'(inputMsg), 256'(0));
        chk("midrst_inputTarget", inputTarget, 256'(0));
        chk("midrst_cur_nonce", 256'(cur_nonce), 256'(0));
        f0 = fnd_cnt;
        e0 = exh_cnt;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_found", 256'(fnd_cnt - f0), 256'(0));
        chk("midrst_no_exh", 256'(exh_cnt - e0), 256'(0));
        chk("midrst_no_msgs", 256'(msg_cnt - m0), 256'(2));
        exp_q.delete();
        run_job(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
